pitch_bucket_selector: RTL and testbench

Producer side of the LED dimmer's `update_strobe`/`active_bucket` interface. Consumes a per-frame stream of (pitch-class bucket, magnitude) beats from the spectral front end and accumulates energy per bucket. At frame end it finds the dominant bucket with a sequential argmax scan. It then issues a one-cycle `update_strobe` with `active_bucket` when the peak energy clears a threshold.

---
 rtl/pitch_pkg.sv | 29 ++
 rtl/bucket_argmax.sv | 50 +++++
 rtl/pitch_bucket_selector.sv | 145 ++++++++++++++
 tb/tb_pitch_bucket_selector.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pitch_pkg.sv
// rtl/pitch_pkg.sv - shared constants, state enum and saturating add for the pitch bucket selector
package pitch_pkg;

  localparam int NUM_BUCKETS    = 12;
  localparam int BUCKET_W       = 4;
  localparam int MAG_W          = 16;
  localparam int ACC_W          = 24;
  localparam int CONFIRM_FRAMES = 2;

  localparam logic [ACC_W-1:0]    THRESH   = 24'd4096;
  localparam logic [BUCKET_W-1:0] LAST_IDX = BUCKET_W'(NUM_BUCKETS - 1);

  typedef enum logic [1:0] {
    ACCUM,
    SCAN,
    DECIDE
  } state_t;

  typedef logic [NUM_BUCKETS-1:0][ACC_W-1:0] acc_array_t;

  // Add a magnitude to an accumulator, clamping at all-ones instead of wrapping.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [MAG_W-1:0] mag);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + {{(ACC_W + 1 - MAG_W){1'b0}}, mag};
    return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/bucket_argmax.sv
// rtl/bucket_argmax.sv - sequential argmax scanner over the per-bucket accumulators
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   start          one-cycle pulse; scanning begins on the following edge
//   acc            accumulator array, must be stable while scanning
//   best, best_idx running maximum and its index (final once done has been seen)
//   done           high during the cycle that examines the last bucket
module bucket_argmax
  import pitch_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  acc_array_t          acc,
  output logic [ACC_W-1:0]    best,
  output logic [BUCKET_W-1:0] best_idx,
  output logic                done
);

  logic                busy;
  logic [BUCKET_W-1:0] idx;

  // Combinational so the caller can leave SCAN on the same edge that
  // registers the final comparison.
  assign done = busy && (idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= 1'b0;
      idx      <= '0;
      best     <= '0;
      best_idx <= '0;
    end else if (start) begin
      busy <= 1'b1;
      idx  <= '0;
    end else if (busy) begin
      // Bucket 0 seeds the maximum; strict compare keeps the lowest index on ties.
      if ((idx == '0) || (acc[idx] > best)) begin
        best     <= acc[idx];
        best_idx <= idx;
      end
      if (idx == LAST_IDX) begin
        busy <= 1'b0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pitch_bucket_selector.sv
// rtl/pitch_bucket_selector.sv - per-frame pitch-class energy accumulator with dominant-bucket strobe
// Optional feature macro: BUCKET_CONFIRM_EN (winner must repeat CONFIRM_FRAMES frames before strobing)
// Ports:
//   clk, reset_n    clock and asynchronous active-low reset
//   in_valid/ready  beat handshake; in_ready is registered and high only while accumulating
//   in_bucket       pitch-class index of the beat (>= NUM_BUCKETS is dropped)
//   in_mag          unsigned beat magnitude
//   in_last         final beat of the frame
//   update_strobe   one-cycle pulse when a new dominant bucket is published
//   active_bucket   last published dominant bucket
//   frame_done      one-cycle pulse at every frame decision
//   peak_energy     winning accumulator value of the last frame
module pitch_bucket_selector
  import pitch_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BUCKET_W-1:0] in_bucket,
  input  logic [MAG_W-1:0]    in_mag,
  input  logic                in_last,
  output logic                update_strobe,
  output logic [BUCKET_W-1:0] active_bucket,
  output logic                frame_done,
  output logic [ACC_W-1:0]    peak_energy
);

  state_t              state;
  state_t              next_state;
  acc_array_t          acc;
  logic                accept;
  logic                start_scan;
  logic                scan_done;
  logic [ACC_W-1:0]    best;
  logic [BUCKET_W-1:0] best_idx;
  logic                above;
  logic                strobe_now;

  assign accept     = (state == ACCUM) && in_valid && in_ready;
  assign start_scan = accept && in_last;
  assign above      = (best >= THRESH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ACCUM;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ACCUM:   if (start_scan) next_state = SCAN;
      SCAN:    if (scan_done)  next_state = DECIDE;
      DECIDE:  next_state = ACCUM;
      default: next_state = ACCUM;
    endcase
  end

  // Ready follows the state we are about to enter, so it drops on the in_last
  // edge and rises on the decision edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready <= 1'b0;
    end else begin
      in_ready <= (next_state == ACCUM);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (state == DECIDE) begin
      acc <= '0;
    end else if (accept && (in_bucket < BUCKET_W'(NUM_BUCKETS))) begin
      acc[in_bucket] <= sat_add(acc[in_bucket], in_mag);
    end
  end

  bucket_argmax u_argmax (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start_scan),
    .acc      (acc),
    .best     (best),
    .best_idx (best_idx),
    .done     (scan_done)
  );

`ifdef BUCKET_CONFIRM_EN
  logic [3:0]          confirm_cnt;
  logic [3:0]          cnt_next;
  logic [BUCKET_W-1:0] candidate;

  always_comb begin
    cnt_next = confirm_cnt;
    if (!above) begin
      cnt_next = '0;
    end else if (best_idx == candidate) begin
      cnt_next = (confirm_cnt == 4'hF) ? confirm_cnt : confirm_cnt + 4'd1;
    end else begin
      cnt_next = 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      confirm_cnt <= '0;
      candidate   <= '0;
    end else if (state == DECIDE) begin
      confirm_cnt <= cnt_next;
      if (above && (best_idx != candidate)) begin
        candidate <= best_idx;
      end
    end
  end

  assign strobe_now = above && (cnt_next >= 4'(CONFIRM_FRAMES));
`else
  assign strobe_now = above;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      update_strobe <= 1'b0;
      frame_done    <= 1'b0;
      active_bucket <= '0;
      peak_energy   <= '0;
    end else begin
      update_strobe <= 1'b0;
      frame_done    <= 1'b0;
      if (state == DECIDE) begin
        frame_done  <= 1'b1;
        peak_energy <= best;
        if (strobe_now) begin
          update_strobe <= 1'b1;
          active_bucket <= best_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_pitch_bucket_selector.sv
// tb/tb_pitch_bucket_selector.sv - directed self-checking bench for pitch_bucket_selector
module tb_pitch_bucket_selector;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_bucket;
  logic [15:0] in_mag;
  logic        in_last;
  logic        update_strobe;
  logic [3:0]  active_bucket;
  logic        frame_done;
  logic [23:0] peak_energy;

  int n_cmp  = 0;
  int n_fail = 0;

  pitch_bucket_selector dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_bucket     (in_bucket),
    .in_mag        (in_mag),
    .in_last       (in_last),
    .update_strobe (update_strobe),
    .active_bucket (active_bucket),
    .frame_done    (frame_done),
    .peak_energy   (peak_energy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called 1 time unit after a rising edge; returns 1 time unit after the edge
  // on which the beat transferred.
  task automatic send_beat(input logic [3:0] b, input logic [15:0] m, input logic l);
    int guard;
    guard     = 0;
    in_valid  = 1'b1;
    in_bucket = b;
    in_mag    = m;
    in_last   = l;
    while ((in_ready !== 1'b1) && (guard < 100)) begin
      @(posedge clk);
      #1;
      guard++;
    end
    n_cmp++;
    if (guard >= 100) begin
      n_fail++;
      $display("FAIL send_beat timeout: in_ready=%b after %0d cycles, want 1", in_ready, guard);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called at E0+1 (just after the in_last handshake). Checks the scan window,
  // the decision cycle after E13 and that the pulses end after E14.
  task automatic frame_end(input logic exp_strobe, input logic [3:0] exp_active,
                           input logic [23:0] exp_peak, input string name);
    int early;
    int ready_hi;
    early    = 0;
    ready_hi = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (update_strobe || frame_done) early++;
      if (in_ready) ready_hi++;
    end
    n_cmp++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL %s early_pulse: got %0d pulse cycles, want 0", name, early);
    end
    n_cmp++;
    if (ready_hi != 0) begin
      n_fail++;
      $display("FAIL %s ready_in_scan: got %0d ready cycles, want 0", name, ready_hi);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (update_strobe !== exp_strobe) begin
      n_fail++;
      $display("FAIL %s strobe: got %b want %b", name, update_strobe, exp_strobe);
    end
    n_cmp++;
    if (frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s frame_done: got %b want 1", name, frame_done);
    end
    n_cmp++;
    if (active_bucket !== exp_active) begin
      n_fail++;
      $display("FAIL %s active_bucket: got %0d want %0d", name, active_bucket, exp_active);
    end
    n_cmp++;
    if (peak_energy !== exp_peak) begin
      n_fail++;
      $display("FAIL %s peak_energy: got %h want %h", name, peak_energy, exp_peak);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_after: got %b want 1", name, in_ready);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ((update_strobe !== 1'b0) || (frame_done !== 1'b0)) begin
      n_fail++;
      $display("FAIL %s pulse_width: got strobe=%b done=%b want 0 0", name, update_strobe, frame_done);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_cmp++;
    if ({in_ready, update_strobe, frame_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s flags: got ready=%b strobe=%b done=%b want 0 0 0",
               name, in_ready, update_strobe, frame_done);
    end
    n_cmp++;
    if (active_bucket !== 4'd0) begin
      n_fail++;
      $display("FAIL %s active_bucket: got %0d want 0", name, active_bucket);
    end
    n_cmp++;
    if (peak_energy !== 24'd0) begin
      n_fail++;
      $display("FAIL %s peak_energy: got %h want 0", name, peak_energy);
    end
  endtask

  task automatic test_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("reset_async");
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold in_ready: got %b want 0", in_ready);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single_frame();
    send_beat(4'd5, 16'd3000, 1'b0);
    send_beat(4'd5, 16'd3000, 1'b0);
    send_beat(4'd2, 16'd100, 1'b1);
    frame_end(1'b1, 4'd5, 24'd6000, "single");
  endtask

  task automatic test_tie();
    send_beat(4'd7, 16'd5000, 1'b0);
    send_beat(4'd3, 16'd5000, 1'b1);
    frame_end(1'b1, 4'd3, 24'd5000, "tie");
  endtask

  task automatic test_threshold();
    send_beat(4'd9, 16'd4000, 1'b0);
    send_beat(4'd9, 16'd95, 1'b1);
    frame_end(1'b0, 4'd3, 24'd4095, "below_thresh");
    send_beat(4'd9, 16'd4096, 1'b1);
    frame_end(1'b1, 4'd9, 24'd4096, "at_thresh");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) send_beat(4'd1, 16'hFFFF, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(4'd14, 16'hFFFF, 1'b0);
    send_beat(4'd14, 16'hFFFF, 1'b1);
    frame_end(1'b1, 4'd1, 24'hFFFFFF, "saturation");
  endtask

  task automatic test_reset_mid_frame();
    send_beat(4'd8, 16'd9000, 1'b0);
    send_beat(4'd8, 16'd9000, 1'b0);
    reset_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(4'd10, 16'd4096, 1'b1);
    frame_end(1'b1, 4'd10, 24'd4096, "after_reset");
  endtask

  task automatic test_backpressure();
    send_beat(4'd11, 16'd100, 1'b1);
    // Offer a beat for the whole scan; it may only transfer on E14.
    in_valid  = 1'b1;
    in_bucket = 4'd0;
    in_mag    = 16'd5000;
    in_last   = 1'b0;
    frame_end(1'b0, 4'd10, 24'd100, "bp_frame");
    in_valid = 1'b0;
    send_beat(4'd0, 16'd0, 1'b1);
    frame_end(1'b1, 4'd0, 24'd5000, "bp_next");
  endtask

  task automatic test_every_frame_strobes();
    send_beat(4'd4, 16'd5000, 1'b1);
    frame_end(1'b1, 4'd4, 24'd5000, "nocfm_f1");
    send_beat(4'd4, 16'd5000, 1'b1);
    frame_end(1'b1, 4'd4, 24'd5000, "nocfm_f2");
    send_beat(4'd6, 16'd5000, 1'b1);
    frame_end(1'b1, 4'd6, 24'd5000, "nocfm_f3");
  endtask

  task automatic test_confirm();
    send_beat(4'd4, 16'd5000, 1'b1);
    frame_end(1'b0, 4'd0, 24'd5000, "cfm_f1");
    send_beat(4'd4, 16'd5000, 1'b1);
    frame_end(1'b1, 4'd4, 24'd5000, "cfm_f2");
    send_beat(4'd6, 16'd5000, 1'b1);
    frame_end(1'b0, 4'd4, 24'd5000, "cfm_f3");
    send_beat(4'd6, 16'd5000, 1'b1);
    frame_end(1'b1, 4'd6, 24'd5000, "cfm_f4");
    send_beat(4'd6, 16'd5000, 1'b1);
    frame_end(1'b1, 4'd6, 24'd5000, "cfm_f5");
  endtask

  initial begin
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    in_bucket = 4'd0;
    in_mag    = 16'd0;
    in_last   = 1'b0;
    test_reset();
`ifdef BUCKET_CONFIRM_EN
    test_confirm();
`else
    test_single_frame();
    test_tie();
    test_threshold();
    test_saturation();
    test_reset_mid_frame();
    test_backpressure();
    test_every_frame_strobes();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
